// File: rtl/moore_seq_pkg.sv
// Shared types and reset constants for the moore_seq_ctrl pattern detector.
package moore_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [3:0]  SEQ_RST_PATTERN = 4'b1001;
    localparam int unsigned SEQ_RST_LEN     = 4;

    // Stored lengths are always within 1..max_len.
    function automatic int unsigned seq_clamp_len(input int unsigned len,
                                                  input int unsigned max_len);
        if (len == 0) return 1;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial match core: history shift register, fill counter, masked compare
// against the low len bits of pattern, and a registered z pulse.
module seq_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               enable,
    input  logic               clear,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit,
    output logic               z
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
    logic               z_q, z_d;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hist_d   = hist_q;
        fill_d   = fill_q;
        fill_inc = (fill_q < len) ? fill_q + LEN_W'(1) : len;
        hit      = 1'b0;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (enable) begin
            hist_d = {hist_q[MAX_LEN-2:0], x};
            fill_d = fill_inc;
            if ((fill_inc == len) && ((hist_d & mask) == (pattern & mask))) begin
                hit = 1'b1;
                // Non-overlapping mode demands len fresh bits before the next hit.
                if (!overlap) fill_d = '0;
            end
        end
        z_d = hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/moore_seq_ctrl.sv
// Run-controlled programmable pattern detector: FSM, config registers, match
// counter. Define MOORE_SEQ_OVERLAP_EN to store and honour cfg_overlap.
//   state | meaning
//   IDLE  | stopped, config writable
//   RUN   | sampling x, counting matches
//   DONE  | target reached, config writable
module moore_seq_ctrl
    import moore_seq_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               x,
    output logic               z,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt
);

    seq_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_ok, core_en, core_clr, hit, overlap_eff;

    assign cfg_ok = cfg_we && (state_q != RUN);

`ifdef MOORE_SEQ_OVERLAP_EN
    logic overlap_q, overlap_d;

    always_comb begin
        overlap_d = overlap_q;
        if (cfg_ok) overlap_d = cfg_overlap;
    end

    always_ff @(posedge clk) begin
        if (rst) overlap_q <= 1'b0;
        else     overlap_q <= overlap_d;
    end

    assign overlap_eff = overlap_q;
`else
    logic cfg_overlap_unused;
    assign cfg_overlap_unused = cfg_overlap;
    assign overlap_eff        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        core_en   = 1'b0;
        core_clr  = 1'b0;
        if (cfg_ok) begin
            pattern_d = cfg_pattern;
            len_d     = LEN_W'(seq_clamp_len(int'(cfg_len), MAX_LEN));
            target_d  = cfg_target;
        end
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    core_clr = 1'b1;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                // stop suppresses sampling, so a coincident final match is lost.
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    core_en = 1'b1;
                    if (hit) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        if ((target_q != '0) && (cnt_d == target_q)) state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= MAX_LEN'(SEQ_RST_PATTERN);
            len_q     <= LEN_W'(SEQ_RST_LEN);
            target_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
        end
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .enable  (core_en),
        .clear   (core_clr),
        .pattern (pattern_q),
        .len     (len_q),
        .overlap (overlap_eff),
        .hit     (hit),
        .z       (z)
    );

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign match_cnt = cnt_q;

endmodule

// File: doc/moore_seq_ctrl.md
# moore_seq_ctrl

Programmable, run-controlled serial pattern detector that sequences a Moore-style match core. It loads a pattern, length, overlap mode and match target through a config port, then arms on `start`. It samples the serial input `x` every clock, pulses `z` once per match, counts matches and stops when the target is reached. The default configuration detects 1001 non-overlapping, matching the existing fixed-pattern Moore detectors.

## Interface
- `MAX_LEN`, 8: longest supported pattern in bits.
- `CNT_W`, 8: match counter and target width.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `cfg_len`. Derived, not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  config write strobe.
- `cfg_pattern`  in  MAX_LEN  pattern; bit `len-1` is the first bit received.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping detection.
- `cfg_target`  in  CNT_W  matches before auto-stop; 0 = unlimited.
- `start`  in  1  arm/run request.
- `stop`  in  1  abort run.
- `x`  in  1  serial data, sampled at every rising edge in RUN.
- `z`  out  1  one-cycle match pulse, registered (Moore).
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `match_cnt`  out  CNT_W  matches in current/last run, saturating.

## Operation
- States are IDLE, RUN and DONE.
- Reset values:
  - State = IDLE; `z`, `busy`, `done` = 0; `match_cnt` = 0.
  - Config registers: pattern = 1001 (low bits), len = 4, overlap = 0, target = 0.
- `cfg_we` is accepted in IDLE/DONE only and ignored in RUN.
- `cfg_len` is clamped on write: 0 stores as 1; values above MAX_LEN store as MAX_LEN.
- IDLE/DONE + `start`: go to RUN. This clears history, fill count and `match_cnt`. If `cfg_we` is high in the same cycle, the new config is written and used by this run.
- RUN + `stop`: go to IDLE. `match_cnt` is held. `x` in that cycle is not sampled. `start` in RUN is ignored.
- Per RUN cycle:
  - history = {history[MAX_LEN-2:0], x}.
  - fill = min(fill+1, len).
  - A match occurs when fill reaches len and history[len-1:0] == pattern[len-1:0].
- On a match:
  - `z` = 1 on the next cycle.
  - `match_cnt` += 1, saturating at all-ones.
  - Non-overlap: fill resets to 0, so the next match needs len fresh bits.
  - Overlap: fill stays at len.
- If the new count equals a nonzero target: go to DONE on the same edge, `busy` = 0 and `done` = 1. DONE holds until `start` or `rst`.
- `stop` and a final match in the same cycle: `stop` wins. No match is counted and there is no `z`.
- `rst` mid-run returns everything to reset values, including the config registers.

## Timing
- Latency: the edge sampling the last pattern bit registers `z`. `z` is high for exactly the following cycle.
- `match_cnt`, `done` and `busy` update on that same edge.
- `busy` rises on the edge after `start` is seen, and falls on the `stop` edge or the target-reached edge.
- The first sampled bit is on the edge after the one that entered RUN.
- Back-to-back matches (overlap, len=1) give `z` high on consecutive cycles.

## Configuration
- `MOORE_SEQ_OVERLAP_EN` defined: `cfg_overlap` is stored and honoured.
- Undefined: the overlap register is removed, `cfg_overlap` is ignored, and detection is always non-overlapping.

## Structure
- Package `moore_seq_pkg` contains:
  - state typedef `seq_state_t` (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - reset constants `SEQ_RST_PATTERN`, `SEQ_RST_LEN`.
- Sub-module `seq_match_core` holds the history shift register, fill counter, masked comparator and registered `z`. It has inputs enable, clear, pattern, len and overlap. The top level holds the FSM, config registers and counter.

## Test plan
- Reset defaults, non-overlap, target 0, start, then stream 0100100101001 → `z` pulses after bits 5 and 13; `match_cnt` = 2.
- With `MOORE_SEQ_OVERLAP_EN` and cfg_overlap = 1, same stream → `z` pulses after bits 5, 8 and 13; `match_cnt` = 3.
- Pattern 110, len 3, target 2, stream 110110110 → DONE after the 6th bit; the third match is ignored; `match_cnt` = 2, `done` = 1.
- `cfg_we` during RUN with pattern 1111 → ignored; detection of 1001 continues.
- `stop` on the cycle sampling the final 1 of 1001 → no `z`, IDLE, `match_cnt` unchanged.
- cfg_len = 0 write, then pattern bit0 = 1, overlap on, stream 111 → three consecutive `z` cycles. Also, `rst` mid-run → all outputs 0 next cycle.
